// File: rtl/ft245_txarb_pkg.sv
// Shared types and helpers for the FT245 transmit arbiter.
package ft245_pkg;

    // Mode sequencer states; only ST_READ hands the interface to the host.
    typedef enum logic [2:0] {
        ST_READ,
        ST_ARB,
        ST_HDR,
        ST_DATA,
        ST_HOLD
    } state_e;

    // Upper nibble of every burst header byte.
    localparam logic [3:0] HDR_TAG = 4'hA;

    // Header byte announcing which source the following payload belongs to.
    function automatic logic [7:0] make_hdr(input logic [2:0] src_id);
        return {HDR_TAG, 1'b0, src_id};
    endfunction

endpackage

// File: rtl/ft245_txarb_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after rr_ptr_i.
module rr_arbiter #(
    parameter int NUM_SRC = 4
) (
    input  logic [NUM_SRC-1:0] req_i,
    input  logic [2:0]         rr_ptr_i,
    output logic [NUM_SRC-1:0] gnt_o,
    output logic [2:0]         gnt_idx_o
);

    // Scan from the pointer with wrap-around and keep the first hit.
    always_comb begin
        logic found;
        int   idx;
        // NOTE: every output gets a value before the loop so no path leaves
        // it unassigned; otherwise synthesis infers a latch.
        gnt_o     = '0;
        gnt_idx_o = '0;
        found     = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            idx = int'(rr_ptr_i) + k;
            if (idx >= NUM_SRC) idx = idx - NUM_SRC;
            if (!found && req_i[idx]) begin
                found      = 1'b1;
                gnt_o[idx] = 1'b1;
                gnt_idx_o  = 3'(idx);
            end
        end
    end

endmodule

// File: rtl/ft245_txarb.sv
// FT245 transmit arbiter: round-robin bursts with tag headers, RWn sequencing.
module ft245_txarb
    import ft245_pkg::*;
#(
    parameter int NUM_SRC   = 4,
    parameter int BURST_MAX = 64,
    parameter int IDLE_HOLD = 8
) (
    input  logic                   Clk,
    input  logic                   ARst,
    input  logic [8*NUM_SRC-1:0]   Src_Data,
    input  logic [NUM_SRC-1:0]     Src_Valid,
    input  logic [NUM_SRC-1:0]     Src_Last,
    output logic [NUM_SRC-1:0]     Src_Rdy,
    input  logic                   Rx_Pend,
    output logic                   RWn,
    output logic [7:0]             Data_Wr,
    output logic                   Valid_Wr,
    input  logic                   Rdy_Wr,
    output logic [2:0]             Grant_Id
);

    localparam int IDLE_W = $clog2(IDLE_HOLD + 1);

    state_e              state_q, state_d;
    logic [2:0]          grant_q, grant_d;
    logic [2:0]          rr_ptr_q, rr_ptr_d;
    logic [7:0]          byte_cnt_q, byte_cnt_d;
    logic [IDLE_W-1:0]   idle_cnt_q, idle_cnt_d;

    logic [NUM_SRC-1:0]  arb_gnt;
    logic [2:0]          arb_idx;
    logic                arb_any;
    logic [NUM_SRC-1:0]  gnt_mask;
    logic [7:0]          src_byte;
    logic                src_valid;
    logic                src_last;
    logic [7:0]          cnt_inc;
    logic [2:0]          ptr_next;

    rr_arbiter #(.NUM_SRC(NUM_SRC)) u_arb (
        .req_i     (Src_Valid),
        .rr_ptr_i  (rr_ptr_q),
        .gnt_o     (arb_gnt),
        .gnt_idx_o (arb_idx)
    );

    assign arb_any  = |arb_gnt;
    assign cnt_inc  = byte_cnt_q + 8'd1;
    assign ptr_next = (grant_q == 3'(NUM_SRC - 1)) ? 3'd0 : grant_q + 3'd1;
    assign Grant_Id = grant_q;
    // Decoded straight from the state register so the mode line never glitches.
    assign RWn      = (state_q == ST_READ);

    // Select the granted source's byte, valid and last flags.
    always_comb begin
        gnt_mask  = '0;
        src_byte  = '0;
        src_valid = 1'b0;
        src_last  = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (grant_q == 3'(i)) begin
                gnt_mask[i] = 1'b1;
                src_byte    = Src_Data[8*i +: 8];
                src_valid   = Src_Valid[i];
                src_last    = Src_Last[i];
            end
        end
    end

    // Next-state and output decode for the mode sequencer.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        rr_ptr_d   = rr_ptr_q;
        byte_cnt_d = byte_cnt_q;
        idle_cnt_d = '0;
        Data_Wr    = 8'h00;
        Valid_Wr   = 1'b0;
        Src_Rdy    = '0;
        unique case (state_q)
            ST_READ: begin
                if (|Src_Valid && !Rx_Pend) state_d = ST_ARB;
            end
            ST_ARB: begin
                if (Rx_Pend || !arb_any) begin
                    state_d = ST_HOLD;
                end else begin
                    grant_d    = arb_idx;
                    byte_cnt_d = 8'd0;
                    state_d    = ST_HDR;
                end
            end
            ST_HDR: begin
                Data_Wr  = make_hdr(grant_q);
                Valid_Wr = 1'b1;
                if (Rdy_Wr) state_d = ST_DATA;
            end
            ST_DATA: begin
                // Pass-through; a burst always runs to Last or BURST_MAX.
                Data_Wr  = src_byte;
                Valid_Wr = src_valid;
                Src_Rdy  = gnt_mask & {NUM_SRC{Rdy_Wr}};
                if (src_valid && Rdy_Wr) begin
                    byte_cnt_d = cnt_inc;
                    if (src_last || cnt_inc == 8'(BURST_MAX)) begin
                        rr_ptr_d = ptr_next;
                        state_d  = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (Rx_Pend) begin
                    state_d = ST_READ;
                end else if (|Src_Valid) begin
                    state_d = ST_ARB;
                end else if (idle_cnt_q >= IDLE_W'(IDLE_HOLD - 1)) begin
                    state_d = ST_READ;
                end else begin
                    idle_cnt_d = (idle_cnt_q == '1) ? idle_cnt_q : idle_cnt_q + 1'b1;
                end
            end
            default: state_d = ST_READ;
        endcase
    end

    // State and counter registers.
    always_ff @(posedge Clk) begin
        // NOTE: reset is sampled on the clock edge; all state here is plain
        // flops, so every register is cleared explicitly.
        if (ARst) begin
            state_q    <= ST_READ;
            grant_q    <= '0;
            rr_ptr_q   <= '0;
            byte_cnt_q <= '0;
            idle_cnt_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge value regardless of statement order.
            state_q    <= state_d;
            grant_q    <= grant_d;
            rr_ptr_q   <= rr_ptr_d;
            byte_cnt_q <= byte_cnt_d;
            idle_cnt_q <= idle_cnt_d;
        end
    end

endmodule
